// File: rtl/johnson_step_pkg.sv
// Shared types and constants for the Johnson ring step sequencer.
package johnson_step_pkg;

  // Sequencer states: waiting for a command, or executing a move.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ring direction encoding as carried on cmd_dir.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_ring.sv
// WIDTH-bit Johnson ring; advances one position per step_en in the given direction.
module johnson_ring
  import johnson_step_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  // Forward shifts the inverted LSB in at the top; reverse shifts the inverted MSB in at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (step_en) begin
      if (dir == DIR_FWD) begin
        q <= {~q[0], q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
      end
    end
  end

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson ring step sequencer.
// Optional macro JSEQ_POS_TRACK_EN adds a signed step-position output 'pos'.
module johnson_step_ctrl
  import johnson_step_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic                    cmd_dir,
  input  logic [DIV_W-1:0]        cmd_div,
  input  logic                    abort,
  output logic [WIDTH-1:0]        q,
`ifdef JSEQ_POS_TRACK_EN
  output logic signed [CNT_W:0]   pos,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned POS_W = CNT_W + 1;

  state_e           state;
  logic [CNT_W-1:0] steps_rem;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_r;
  logic             dir_r;
  logic             step_en_c;

  // A step fires on a RUN edge whose prescaler has expired, unless abort pre-empts it.
  assign step_en_c = (state == RUN) && !abort && (presc == '0);

  // Sequencer FSM with prescaler, remaining-step counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      steps_rem <= '0;
      presc     <= '0;
      div_r     <= '0;
      dir_r     <= DIR_FWD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            div_r     <= cmd_div;
            dir_r     <= cmd_dir;
            steps_rem <= cmd_steps;
            presc     <= cmd_div;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (presc == '0) begin
            steps_rem <= steps_rem - CNT_W'(1);
            presc     <= div_r;
            if (steps_rem == CNT_W'(1)) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            presc <= presc - DIV_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef JSEQ_POS_TRACK_EN
  // Signed position follows every step taken; wraps in two's complement.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (step_en_c) begin
      if (dir_r == DIR_FWD) begin
        pos <= pos + POS_W'(1);
      end else begin
        pos <= pos - POS_W'(1);
      end
    end
  end
`endif

  johnson_ring #(
    .WIDTH(WIDTH)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .step_en(step_en_c),
    .dir    (dir_r),
    .q      (q)
  );

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Self-checking bench for johnson_step_ctrl: directed scenarios plus randomized moves
// against a phase-index reference model.
module tb_johnson_step_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 16;
  localparam int          NPH   = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef JSEQ_POS_TRACK_EN
  logic signed [CNT_W:0] pos;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int ph       = 0;   // model ring phase, 0..NPH-1, phase 0 = all zeros
  int pos_exp  = 0;   // model signed position

  johnson_step_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_dir  (cmd_dir),
    .cmd_div  (cmd_div),
    .abort    (abort),
    .q        (q),
`ifdef JSEQ_POS_TRACK_EN
    .pos      (pos),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Johnson pattern for phase k: forward from zero fills ones from the MSB, then drains from the MSB.
  function automatic logic [WIDTH-1:0] johnson_of(input int k);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) v[i] = (i >= WIDTH - k);
      else            v[i] = (i < NPH - k);
    end
    return v;
  endfunction

  function automatic int advance(input int p, input int d, input int n);
    int m;
    m = n % NPH;
    return (d == 0) ? (p + m) % NPH : (p + NPH - m) % NPH;
  endfunction

  task automatic chk_state(input string tag, input logic e_busy, input logic e_done, input int e_ph);
    chk({tag, ".q"},    32'(q),         32'(johnson_of(e_ph)));
    chk({tag, ".busy"}, 32'(busy),      32'(e_busy));
    chk({tag, ".done"}, 32'(done),      32'(e_done));
    chk({tag, ".rdy"},  32'(cmd_ready), 32'(!e_busy));
`ifdef JSEQ_POS_TRACK_EN
    chk({tag, ".pos"},  32'(unsigned'(pos)), 32'(pos_exp & ((1 << (CNT_W + 1)) - 1)));
`endif
  endtask

  // Issue one command in the current (idle) cycle and follow it to completion.
  // abort_at: RUN edge number (1-based after accept) at which abort is raised, 0 = none.
  task automatic do_move(input string tag, input int steps, input int dir, input int div,
                         input int abort_at, input bit hold_valid, input bit idle_abort);
    int total, last, k, taken, start;
    chk({tag, ".pre_rdy"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(steps);
    cmd_dir   = dir[0];
    cmd_div   = DIV_W'(div);
    abort     = idle_abort;
    @(posedge clk); #1;
    abort     = 1'b0;
    cmd_valid = hold_valid;
    cmd_steps = CNT_W'($urandom);
    cmd_dir   = 1'($urandom);
    cmd_div   = DIV_W'($urandom);
    if (steps == 0) begin
      cmd_valid = 1'b0;
      chk_state({tag, ".zero"}, 1'b0, 1'b1, ph);
      return;
    end
    chk_state({tag, ".acc"}, 1'b1, 1'b0, ph);
    total = (div + 1) * steps;
    last  = (abort_at > 0 && abort_at <= total) ? abort_at : total;
    start = ph;
    for (int n = 1; n <= last; n++) begin
      abort = (n == abort_at);
      @(posedge clk); #1;
      abort = 1'b0;
      k     = (n == abort_at) ? n - 1 : n;
      taken = k / (div + 1);
      ph    = advance(start, dir, taken);
      if (n == last) begin
        pos_exp += (dir == 0) ? taken : -taken;
        cmd_valid = 1'b0;
        chk_state({tag, ".end"}, 1'b0, 1'b1, ph);
      end else begin
        chk({tag, ".run.q"},    32'(q),    32'(johnson_of(ph)));
        chk({tag, ".run.busy"}, 32'(busy), 32'd1);
        chk({tag, ".run.done"}, 32'(done), 32'd0);
        if (hold_valid) begin
          cmd_steps = CNT_W'($urandom);
          cmd_div   = DIV_W'($urandom);
        end
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk_state(tag, 1'b0, 1'b0, ph);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ph = 0;
    pos_exp = 0;
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    cmd_div   = '0;
    abort     = 1'b0;
    do_reset();
    chk_state("reset", 1'b0, 1'b0, 0);

    // Full forward revolution at full rate, cmd_valid held while busy.
    do_move("fwd8", 8, 0, 0, 0, 1'b1, 1'b0);
    idle_cycle("fwd8.idle");
    // Reverse with divider, then zero-step command.
    do_move("rev3", 3, 1, 2, 0, 1'b0, 1'b0);
    chk("rev3.q_hold", 32'(q), 32'b0111);
    idle_cycle("rev3.idle");
    do_move("zero", 0, 0, 1, 0, 1'b0, 1'b0);
    idle_cycle("zero.idle");
    // Back to phase zero, then abort at the 4th RUN edge.
    do_move("rewind", 3, 0, 0, 0, 1'b0, 1'b0);
    chk("rewind.q0", 32'(q), 32'd0);
    do_move("abort4", 8, 0, 0, 4, 1'b0, 1'b0);
    // Back-to-back: next command in the done cycle; abort coinciding with the final step.
    do_move("b2b", 2, 1, 0, 0, 1'b0, 1'b1);
    do_move("abort_last", 2, 0, 1, 4, 1'b0, 1'b0);
    idle_cycle("abort_last.idle");

    // Randomized moves with random gaps, aborts and held cmd_valid.
    for (int t = 0; t < 40; t++) begin
      int s, d, v, a, gap;
      s   = $urandom_range(0, 12);
      d   = $urandom_range(0, 1);
      v   = $urandom_range(0, 3);
      a   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (v + 1) * (s + 1)) : 0;
      do_move("rnd", s, d, v, a, 1'($urandom), 1'($urandom));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle("rnd.idle");
    end

    // Reset in the middle of a move at q=1111: no done, everything back to reset values.
    do_reset();
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(8);
    cmd_dir   = 1'b0;
    cmd_div   = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid.q1111", 32'(q), 32'b1111);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ph = 0;
    pos_exp = 0;
    chk_state("mid.rst", 1'b0, 1'b0, 0);
    idle_cycle("mid.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
